// File: rtl/md_pkg.sv
// Shared types and default latencies for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } md_state_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide responder with architectural HI/LO registers.
// Results are computed at the start edge, held as pending, and committed
// to HI/LO when the fixed busy latency expires.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic [2:0]  opt,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_t   state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [31:0] ph, phNext;
    logic [31:0] pl, plNext;
    logic        divZero, divZeroNext;
    logic        busyNext;
    logic [31:0] hiNext, loNext;

    logic [63:0] prodS, prodU;
    logic [31:0] divisorU, quoU, remU;
    logic [31:0] absA, absB, quoMag, remMag, quoS, remS;
    logic        negA, negB;

    // Inline arithmetic on the live operands; only sampled on a start edge.
    // Signed divide is done on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // instead of overflowing, and a zero divisor is replaced by one so the
    // (discarded) result is never X.
    always_comb begin
        prodS    = $signed({{32{v1[31]}}, v1}) * $signed({{32{v2[31]}}, v2});
        prodU    = {32'd0, v1} * {32'd0, v2};
        divisorU = (v2 == 32'd0) ? 32'd1 : v2;
        quoU     = v1 / divisorU;
        remU     = v1 % divisorU;
        negA     = v1[31];
        negB     = v2[31];
        absA     = negA ? (32'd0 - v1) : v1;
        absB     = (v2 == 32'd0) ? 32'd1 : (negB ? (32'd0 - v2) : v2);
        quoMag   = absA / absB;
        remMag   = absA % absB;
        quoS     = (negA ^ negB) ? (32'd0 - quoMag) : quoMag;
        remS     = negA ? (32'd0 - remMag) : remMag;
    end

    // Next-state, pending-result and HI/LO update logic.
    always_comb begin
        stateNext   = state;
        countNext   = count;
        phNext      = ph;
        plNext      = pl;
        divZeroNext = divZero;
        busyNext    = busy;
        hiNext      = hi;
        loNext      = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (opt)
                        MD_MULT, MD_MULTU: begin
                            {phNext, plNext} = (opt == MD_MULT) ? prodS : prodU;
                            divZeroNext      = 1'b0;
                            countNext        = CW'(MULT_CYCLES);
                            stateNext        = MUL;
                            busyNext         = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            plNext      = (opt == MD_DIV) ? quoS : quoU;
                            phNext      = (opt == MD_DIV) ? remS : remU;
                            divZeroNext = (v2 == 32'd0);
                            countNext   = CW'(DIV_CYCLES);
                            stateNext   = DIV;
                            busyNext    = 1'b1;
                        end
                        MD_MTHI: hiNext = v1;
                        MD_MTLO: loNext = v1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                countNext = count - CW'(1);
                if (count == CW'(1)) begin
                    if (!divZero) begin
                        hiNext = ph;
                        loNext = pl;
                    end
                    busyNext  = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            ph      <= '0;
            pl      <= '0;
            divZero <= 1'b0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= stateNext;
            count   <= countNext;
            ph      <= phNext;
            pl      <= plNext;
            divZero <= divZeroNext;
            busy    <= busyNext;
            hi      <= hiNext;
            lo      <= loNext;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random stimulus
// against a behavioural HI/LO model.
module tb_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] v1, v2;
    logic [2:0]  opt;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        mBusy;
    logic [31:0] mHi, mLo, pHi, pLo;
    logic        pValid;
    int          left;

    muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .v1    (v1),
        .v2    (v2),
        .opt   (opt),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int          sa, sb;
        longint      ps, qs, rs;
        logic [63:0] pu;
        if (!reset) begin
            mBusy = 1'b0; mHi = '0; mLo = '0; left = 0; pValid = 1'b0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                mBusy = 1'b0;
                if (pValid) begin
                    mHi = pHi; mLo = pLo;
                end
            end
        end else if (start) begin
            sa = v1; sb = v2;
            case (opt)
                3'd0: begin
                    ps = longint'(sa) * longint'(sb);
                    pHi = ps[63:32]; pLo = ps[31:0];
                    pValid = 1'b1; left = MULT_N; mBusy = 1'b1;
                end
                3'd1: begin
                    pu = 64'(v1) * 64'(v2);
                    pHi = pu[63:32]; pLo = pu[31:0];
                    pValid = 1'b1; left = MULT_N; mBusy = 1'b1;
                end
                3'd2: begin
                    pValid = (v2 != 0);
                    if (pValid) begin
                        qs = longint'(sa) / longint'(sb);
                        rs = longint'(sa) % longint'(sb);
                        pLo = qs[31:0]; pHi = rs[31:0];
                    end
                    left = DIV_N; mBusy = 1'b1;
                end
                3'd3: begin
                    pValid = (v2 != 0);
                    if (pValid) begin
                        pLo = v1 / v2; pHi = v1 % v2;
                    end
                    left = DIV_N; mBusy = 1'b1;
                end
                3'd4: mHi = v1;
                3'd5: mLo = v1;
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        checkVal("busy", 32'(busy), 32'(mBusy));
        checkVal("hi", hi, mHi);
        checkVal("lo", lo, mLo);
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        opt = op; v1 = a; v2 = b; start = 1'b1;
        cycle();
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        reset = 1'b0; start = 1'b0; opt = '0; v1 = '0; v2 = '0;
        mBusy = 1'b0; mHi = '0; mLo = '0; pHi = '0; pLo = '0; pValid = 1'b0; left = 0;
        cycle();
        cycle();
        reset = 1'b1;

        // mult -3 * 5, busy length
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        bc = int'(busy);
        repeat (MULT_N + 1) begin
            cycle();
            bc += int'(busy);
        end
        checkVal("multBusyLen", 32'(bc), 32'd5);
        checkVal("multHi", hi, 32'hFFFF_FFFF);
        checkVal("multLo", lo, 32'hFFFF_FFF1);

        // multu
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        repeat (MULT_N) cycle();
        checkVal("multuHi", hi, 32'h0000_0001);
        checkVal("multuLo", lo, 32'hFFFF_FFFE);

        // div -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (DIV_N) cycle();
        checkVal("divLo", lo, 32'hFFFF_FFFD);
        checkVal("divHi", hi, 32'hFFFF_FFFF);

        // divu by zero leaves HI/LO alone
        issue(3'd3, 32'd7, 32'd0);
        bc = int'(busy);
        repeat (DIV_N) begin
            cycle();
            bc += int'(busy);
        end
        checkVal("div0BusyLen", 32'(bc), 32'd10);
        checkVal("div0Lo", lo, 32'hFFFF_FFFD);
        checkVal("div0Hi", hi, 32'hFFFF_FFFF);

        // mthi / mtlo back to back
        issue(3'd4, 32'h1234_5678, 32'd0);
        checkVal("mthiBusy", 32'(busy), 32'd0);
        checkVal("mthiHi", hi, 32'h1234_5678);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);
        checkVal("mtloBusy", 32'(busy), 32'd0);
        checkVal("mtloLo", lo, 32'h9ABC_DEF0);

        // signed overflow
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DIV_N) cycle();
        checkVal("ovfLo", lo, 32'h8000_0000);
        checkVal("ovfHi", hi, 32'h0000_0000);

        // start during busy ignored, operands captured at start edge
        issue(3'd2, 32'd100, 32'd7);
        cycle();
        cycle();
        issue(3'd4, 32'hDEAD_BEEF, 32'd3);
        repeat (DIV_N - 3) cycle();
        checkVal("ignHi", hi, 32'd2);
        checkVal("ignLo", lo, 32'd14);

        // reset mid-operation discards pending result
        issue(3'd0, 32'd3, 32'd4);
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        checkVal("rstBusy", 32'(busy), 32'd0);
        checkVal("rstHi", hi, 32'd0);
        checkVal("rstLo", lo, 32'd0);
        repeat (MULT_N + 2) cycle();
        checkVal("noCommitLo", lo, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            opt   = 3'($urandom_range(0, 7));
            v1    = randOperand();
            v2    = randOperand();
            start = ($urandom_range(0, 2) == 0);
            cycle();
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (DIV_N + 1) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
